// File: rtl/wb_grf_pkg.sv
// Shared CPU constants for the general register file: reset PC,
// default register-file geometry and the hard-wired zero register index.
package wb_grf_pkg;

  // Default architectural register width and index width
  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;

  // PC value that last_pc holds out of reset
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // Index of the register that always reads as zero and never commits
  localparam int REG_ZERO_IDX = 0;

endpackage : wb_grf_pkg

// File: rtl/wb_grf_bypass.sv
// Per-read-port compare-and-select: returns zero for the zero register,
// forwards the write-back data on a same-cycle index match, otherwise the
// stored register value. Purely combinational and independent of reset.
module grf_bypass
  import wb_grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rd
);

  logic ra_zero_s;
  logic hit_s;

  assign ra_zero_s = (ra == ADDR_W'(REG_ZERO_IDX));
  assign hit_s     = we && (wa != ADDR_W'(REG_ZERO_IDX)) && (ra == wa);

  // Select zero, forwarded write data, or the stored register value
  always_comb begin
    rd = {DATA_W{1'b0}};
    if (ra_zero_s) begin
      rd = {DATA_W{1'b0}};
    end else if (hit_s) begin
      rd = wd;
    end else begin
      rd = rf_rd;
    end
  end

endmodule : grf_bypass

// File: rtl/wb_grf.sv
// General register file with one write port (W stage), two combinational
// read ports (D stage) with write-through bypass, and commit tracking
// (number of committed writes and PC of the latest one).
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [31:0]       PC_W,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [31:0]       commit_cnt,
  output logic [31:0]       last_pc
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [31:0]       commit_cnt_q;
  logic [31:0]       commit_cnt_d;
  logic [31:0]       last_pc_q;
  logic [31:0]       last_pc_d;
  logic              commit_s;

  // A write commits only when enabled and not aimed at the zero register
  assign commit_s = WE && (WA != ADDR_W'(REG_ZERO_IDX));

  // Next-state for the register array and commit tracking
  always_comb begin
    regs_d       = regs_q;
    commit_cnt_d = commit_cnt_q;
    last_pc_d    = last_pc_q;
    if (commit_s) begin
      regs_d[WA]   = WD;
      commit_cnt_d = commit_cnt_q + 32'd1;
      last_pc_d    = PC_W;
    end else begin
      regs_d       = regs_q;
      commit_cnt_d = commit_cnt_q;
      last_pc_d    = last_pc_q;
    end
    regs_d[REG_ZERO_IDX] = {DATA_W{1'b0}};
  end

  // State registers; reset clears everything immediately, dropping any pending write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      commit_cnt_q <= 32'd0;
      last_pc_q    <= RESET_PC;
    end else begin
      regs_q       <= regs_d;
      commit_cnt_q <= commit_cnt_d;
      last_pc_q    <= last_pc_d;
    end
  end

  assign commit_cnt = commit_cnt_q;
  assign last_pc    = last_pc_q;

  grf_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_byp_rd1 (
    .ra    (RA1),
    .we    (WE),
    .wa    (WA),
    .wd    (WD),
    .rf_rd (regs_q[RA1]),
    .rd    (RD1)
  );

  grf_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_byp_rd2 (
    .ra    (RA2),
    .we    (WE),
    .wa    (WA),
    .wd    (WD),
    .rf_rd (regs_q[RA2]),
    .rd    (RD2)
  );

endmodule : wb_grf

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 Parameter DATA_W, default 32, data width of every architectural register.
REQ-002 Parameter ADDR_W, default 5, register index width; register count is 2**ADDR_W.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; registers clear while reset=0.
REQ-005 WE  in  1  write enable from the W stage; decoded upstream from Instr_W.
REQ-006 WA  in  ADDR_W  write register index; carries RFWA_W.
REQ-007 WD  in  DATA_W  write data; ALUout_W, DMRD_W or link value, selected upstream.
REQ-008 PC_W  in  32  PC of the instruction being written back; used for commit tracking only.
REQ-009 RA1, RA2  in  ADDR_W  D-stage read indices (rs, rt).
REQ-010 RD1, RD2  out  DATA_W  read data for RA1 and RA2.
REQ-011 commit_cnt  out  32  count of committed register writes.
REQ-012 last_pc  out  32  PC_W of the most recent committed write.

Function
REQ-013 Commit: on a rising edge with WE=1 and WA!=0, reg[WA] SHALL take WD; commit_cnt SHALL increment by 1; last_pc SHALL take PC_W.
REQ-014 WE=1 with WA=0 SHALL NOT change any register, commit_cnt or last_pc.
REQ-015 WE=0 SHALL NOT change any state.
REQ-016 Register 0 SHALL read as 0 on both ports at all times.
REQ-017 Reads are combinational with zero latency: RDn = reg[RAn] when there is no bypass hit.
REQ-018 Write-through bypass: when WE=1, WA!=0 and RAn==WA in the same cycle, RDn SHALL equal WD before the edge.
REQ-019 RA1==RA2 SHALL return identical data on both ports, including during a bypass hit.
REQ-020 commit_cnt SHALL wrap from 32'hFFFFFFFF to 0 with no flag.
REQ-021 Only one write port exists; a write and reads of the same index in one cycle are resolved by REQ-018.

Reset
REQ-022 While reset=0, all registers SHALL be 0, commit_cnt SHALL be 0 and last_pc SHALL be 32'h00003000, regardless of clk.
REQ-023 Reset asserted mid-cycle SHALL take effect immediately; a write pending at that edge SHALL be lost.
REQ-024 The first commit SHALL occur on the first rising edge with reset=1 and a qualifying write.
REQ-025 While reset=0, RD1 and RD2 SHALL be 0 except on a bypass hit; bypass logic is combinational and reset-independent.

Structure
REQ-026 The shared CPU package SHALL hold: reset PC 32'h00003000, DATA_W/ADDR_W defaults, and the register-0 index constant.
REQ-027 One sub-module, grf_bypass (combinational compare-and-select per read port), SHALL be instantiated twice.
REQ-028 The register array SHALL be a single flop array; no memory macro inference is required.

Verification
REQ-029 Scenario 1, reset: drive reset=0 for 2 cycles, then release -> all RA reads 0, commit_cnt=0, last_pc=32'h00003000.
REQ-030 Scenario 2, write then read: WE=1, WA=8, WD=32'h12345678, PC_W=32'h3004, one edge -> RD1 (RA1=8) = 32'h12345678, commit_cnt=1, last_pc=32'h3004.
REQ-031 Scenario 3, register 0: WE=1, WA=0, WD=32'hFFFFFFFF -> RD1 (RA1=0) = 0, commit_cnt unchanged.
REQ-032 Scenario 4, bypass: reg[9]=1; in the same cycle WE=1, WA=9, WD=5, RA1=RA2=9 -> RD1=RD2=5 before the edge, reg[9]=5 after.
REQ-033 Scenario 5, async reset: reset=0 between edges right after reg[8] is written -> RD1=0 immediately, with no clock edge.
REQ-034 Scenario 6, wrap: force commit_cnt to 32'hFFFFFFFF, then one valid write -> commit_cnt=0.
